elastic_pipe_reg: RTL and testbench

//  Parametrised multi-stage pipeline register with a valid/ready handshake, global stall and flush.

---
 rtl/elastic_pipe_reg.sv | 94 +++++++++
 tb/tb_elastic_pipe_reg.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/elastic_pipe_reg.sv
// Multi-stage elastic pipeline register with valid/ready handshake, global stall and flush.
// Empty stages collapse so upstream keeps moving while downstream is blocked.
module elastic_pipe_reg #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 2,
  parameter bit          CLEAR_DATA = 1'b0
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       STALL,
  input  logic                       FLUSH,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned OccW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] adv, take;
  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [WIDTH-1:0] dat_d [DEPTH];
  logic [OccW-1:0]  occ_q, occ_d;

  // Advance chain runs from the output back to stage 0; a carries adv of the current stage.
  always_comb begin
    logic a;
    adv = '0;
    a   = out_ready;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      adv[i] = a;
      a      = ~vld_q[i] | a;
    end
    take = ~vld_q | adv;
  end

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (FLUSH) begin
      vld_d = '0;
      if (CLEAR_DATA) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          dat_d[i] = '0;
        end
      end
    end else if (!STALL) begin
      if (take[0]) begin
        vld_d[0] = in_valid;
        dat_d[0] = in_data;
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (take[i]) begin
          vld_d[i] = vld_q[i-1];
          dat_d[i] = dat_q[i-1];
        end
      end
    end
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      occ_d = occ_d + OccW'(vld_d[i]);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_q <= '0;
      occ_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      occ_q <= occ_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

  // RST_N gating keeps in_ready low while reset is held, even though all stages are empty.
  assign in_ready  = RST_N & ~STALL & ~FLUSH & take[0];
  assign out_valid = vld_q[DEPTH-1] & ~STALL;
  assign out_data  = dat_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Scoreboard bench for elastic_pipe_reg (WIDTH=8, DEPTH=3): directed vectors, decoupled monitor.
module tb_elastic_pipe_reg;

  localparam int unsigned W = 8;
  localparam int unsigned D = 3;

  logic         CLK = 1'b0;
  logic         RST_N, STALL, FLUSH, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;
  logic         c_in_ready, c_out_valid;
  logic [W-1:0] c_out_data;
  logic [1:0]   c_occupancy;

  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] sb [$];
  logic [W-1:0] exp_q;

  always #5 CLK = ~CLK;

  elastic_pipe_reg #(.WIDTH(W), .DEPTH(D), .CLEAR_DATA(1'b0)) dut (
    .CLK(CLK), .RST_N(RST_N), .STALL(STALL), .FLUSH(FLUSH),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy)
  );

  elastic_pipe_reg #(.WIDTH(W), .DEPTH(D), .CLEAR_DATA(1'b1)) dut_c (
    .CLK(CLK), .RST_N(RST_N), .STALL(STALL), .FLUSH(FLUSH),
    .in_valid(in_valid), .in_data(in_data), .in_ready(c_in_ready),
    .out_valid(c_out_valid), .out_data(c_out_data), .out_ready(out_ready),
    .occupancy(c_occupancy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, want);
    end
  endtask

  task automatic drive(input logic s, input logic f, input logic iv, input logic [W-1:0] d,
                       input logic ordy);
    STALL     = s;
    FLUSH     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  // Mid-cycle sample point; accepted words become expected outputs.
  task automatic mid();
    @(negedge CLK);
    if (RST_N && in_valid && in_ready) sb.push_back(in_data);
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(input string tag);
    bit done = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    for (int k = 0; k < 8 && !done; k++) begin
      mid();
      if (occupancy == 2'd0) done = 1'b1;
      nxt();
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  // Monitor: every output transfer must match the oldest accepted word.
  always @(negedge CLK) begin
    if (!RST_N || FLUSH) begin
      sb.delete();
    end else if (out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL mon_unexpected: got=%0h want=none", out_data);
      end else begin
        exp_q = sb.pop_front();
        if (out_data !== exp_q) begin
          bad++;
          $display("FAIL mon_data: got=%0h want=%0h", out_data, exp_q);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    RST_N = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    nxt();
    nxt();
    RST_N = 1'b1;

    // Latency and back-to-back throughput
    drive(1'b0, 1'b0, 1'b1, 8'h11, 1'b1); mid(); chk("t2_in_ready", in_ready, 1); nxt();
    drive(1'b0, 1'b0, 1'b1, 8'h22, 1'b1); mid(); chk("t2_lat1", out_valid, 0); nxt();
    drive(1'b0, 1'b0, 1'b1, 8'h33, 1'b1); mid(); chk("t2_lat2", out_valid, 0); nxt();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    mid(); chk("t2_lat3_valid", out_valid, 1); chk("t2_d11", out_data, 8'h11);
    chk("t2_occ3", occupancy, 3); nxt();
    mid(); chk("t2_d22", out_data, 8'h22); chk("t2_occ2", occupancy, 2); nxt();
    mid(); chk("t2_d33", out_data, 8'h33); chk("t2_occ1", occupancy, 1); nxt();
    mid(); chk("t2_empty", out_valid, 0); chk("t2_occ0", occupancy, 0); nxt();

    // Backpressure and full pass-through
    drive(1'b0, 1'b0, 1'b1, 8'hA1, 1'b0); mid(); chk("t3_rdy1", in_ready, 1); nxt();
    drive(1'b0, 1'b0, 1'b1, 8'hA2, 1'b0); mid(); chk("t3_rdy2", in_ready, 1); nxt();
    drive(1'b0, 1'b0, 1'b1, 8'hA3, 1'b0); mid(); chk("t3_rdy3", in_ready, 1); nxt();
    drive(1'b0, 1'b0, 1'b1, 8'hA4, 1'b0);
    mid(); chk("t3_full_rdy", in_ready, 0); chk("t3_full_occ", occupancy, 3); nxt();
    drive(1'b0, 1'b0, 1'b1, 8'hA4, 1'b1);
    mid(); chk("t3_pass_rdy", in_ready, 1); chk("t3_pass_dA1", out_data, 8'hA1); nxt();
    drive(1'b0, 1'b0, 1'b1, 8'hA5, 1'b1);
    mid(); chk("t3_pass_occ", occupancy, 3); chk("t3_pass_dA2", out_data, 8'hA2); nxt();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    mid(); chk("t3_pass_occ2", occupancy, 3); chk("t3_pass_dA3", out_data, 8'hA3); nxt();
    drain("t3_drain");

    // Bubble collapse: build vld={1,0,1}, then one edge with output blocked
    drive(1'b0, 1'b0, 1'b1, 8'hB1, 1'b0); mid(); nxt();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);    mid(); nxt();
    drive(1'b0, 1'b0, 1'b1, 8'hB2, 1'b0); mid(); chk("t4_rdy_pre", in_ready, 1); nxt();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    mid(); chk("t4_occ_gap", occupancy, 2); chk("t4_rdy_gap", in_ready, 1);
    chk("t4_out_B1", out_data, 8'hB1); nxt();
    mid(); chk("t4_occ_after", occupancy, 2); chk("t4_rdy_after", in_ready, 1); nxt();

    // Stall holds everything and hides the output
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 1'b1, 8'hCC, 1'b1);
      mid();
      chk("t5_stall_valid", out_valid, 0);
      chk("t5_stall_rdy", in_ready, 0);
      chk("t5_stall_occ", occupancy, 2);
      chk("t5_stall_data", out_data, 8'hB1);
      nxt();
    end
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    mid(); chk("t5_rel_valid", out_valid, 1); chk("t5_rel_B1", out_data, 8'hB1); nxt();
    mid(); chk("t5_rel_valid2", out_valid, 1); chk("t5_rel_B2", out_data, 8'hB2); nxt();
    mid(); chk("t5_rel_empty", out_valid, 0); chk("t5_rel_occ", occupancy, 0); nxt();

    // Flush beats stall and drops the concurrent input
    drive(1'b0, 1'b0, 1'b1, 8'hC1, 1'b0); mid(); nxt();
    drive(1'b0, 1'b0, 1'b1, 8'hC2, 1'b0); mid(); nxt();
    drive(1'b0, 1'b0, 1'b1, 8'hC3, 1'b0); mid(); nxt();
    drive(1'b1, 1'b1, 1'b1, 8'h5A, 1'b0);
    mid(); chk("t6_fl_rdy", in_ready, 0); chk("t6_fl_valid", out_valid, 0);
    chk("t6_fl_occ_pre", occupancy, 3); chk("t6_c_pre", c_out_data, 8'hC1); nxt();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    mid(); chk("t6_occ", occupancy, 0); chk("t6_valid", out_valid, 0);
    chk("t6_c_occ", c_occupancy, 0); chk("t6_c_valid", c_out_valid, 0);
    chk("t6_c_data", c_out_data, 0); nxt();
    for (int k = 0; k < 4; k++) begin
      mid(); chk("t6_no_5a", out_valid, 0); nxt();
    end

    // Asynchronous reset mid-stream
    drive(1'b0, 1'b0, 1'b1, 8'hD1, 1'b0); mid(); nxt();
    drive(1'b0, 1'b0, 1'b1, 8'hD2, 1'b0); mid(); nxt();
    drive(1'b0, 1'b0, 1'b1, 8'hD3, 1'b0); mid(); nxt();
    drive(1'b0, 1'b0, 1'b1, 8'hD4, 1'b0);
    mid(); chk("t1_pre_valid", out_valid, 1); chk("t1_pre_occ", occupancy, 3);
    #1 RST_N = 1'b0;
    #1;
    chk("t1_valid", out_valid, 0);
    chk("t1_occ", occupancy, 0);
    chk("t1_data", out_data, 0);
    chk("t1_rdy", in_ready, 0);
    chk("t1_c_rdy", c_in_ready, 0);
    nxt();
    nxt();
    RST_N = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    mid(); chk("t1_post_occ", occupancy, 0); chk("t1_post_valid", out_valid, 0); nxt();

    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
